tmr_seq_fsm: RTL and testbench



---
 rtl/tmr_seq_pkg.sv | 42 ++++
 rtl/majority_voter_array.sv | 19 +
 rtl/tmr_seq_fsm_next_state.sv | 90 +++++++++
 rtl/tmr_seq_fsm.sv | 131 +++++++++++++
 tb/tb_tmr_seq_fsm.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tmr_seq_pkg.sv
// Shared types and default configuration for the TMR sequence recogniser.
// The state struct widths follow the default sequence geometry below.
package tmr_seq_pkg;

   localparam int DATA_W_C  = 8;
   localparam int NUM_SEQ_C = 2;
   localparam int SEQ_LEN_C = 3;
   localparam int TIMEOUT_C = 16;

   localparam logic [NUM_SEQ_C*SEQ_LEN_C*DATA_W_C-1:0] SEQ_C =
      {8'hB3, 8'hB2, 8'hB1, 8'hA3, 8'hA2, 8'hA1};

   localparam int SID_W_C = (NUM_SEQ_C > 1) ? $clog2(NUM_SEQ_C) : 1;
   localparam int POS_W_C = $clog2(SEQ_LEN_C);
   localparam int TMR_W_C = $clog2(TIMEOUT_C + 1);

   localparam int TMR_MULTIPLICITY_C = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MATCH = 2'd1,
      DONE  = 2'd2,
      ERROR = 2'd3
   } tmr_seq_mode_e;

   typedef struct packed {
      tmr_seq_mode_e        mode;
      logic [SID_W_C-1:0]   seq_id;
      logic [POS_W_C-1:0]   pos;
      logic [TMR_W_C-1:0]   timer;
   } tmr_seq_state_t;

   localparam int STATE_W_C = $bits(tmr_seq_state_t);

   function automatic tmr_seq_state_t tmr_seq_reset_state();
      tmr_seq_state_t s;
      s = '0;
      s.mode = IDLE;
      return s;
   endfunction

endpackage

// File: rtl/majority_voter_array.sv
// Bitwise K-way majority voter: each output bit is set when more than half
// of the K_MMR input copies have that bit set.
module majority_voter_array #(
   parameter int K_MMR = 3,
   parameter int N     = 1
) (
   input  logic [K_MMR*N-1:0] i_data,
   output logic [N-1:0]       o_voted
);

   for (genvar b = 0; b < N; b++) begin : g_bit
      logic [K_MMR-1:0] w_slice;
      for (genvar r = 0; r < K_MMR; r++) begin : g_rep
         assign w_slice[r] = i_data[r*N + b];
      end
      assign o_voted[b] = ($countones(w_slice) > (K_MMR / 2));
   end

endmodule

// File: rtl/tmr_seq_fsm_next_state.sv
// Combinational next-state function of one replica of the sequence recogniser.
// It sees only the voted state, so a corrupted replica is rewritten next cycle.
module tmr_seq_next_state
   import tmr_seq_pkg::*;
#(
   parameter int DATA_W_G  = DATA_W_C,
   parameter int NUM_SEQ_G = NUM_SEQ_C,
   parameter int SEQ_LEN_G = SEQ_LEN_C,
   parameter int TIMEOUT_G = TIMEOUT_C,
   parameter logic [NUM_SEQ_G*SEQ_LEN_G*DATA_W_G-1:0] SEQ_G = SEQ_C
) (
   input  tmr_seq_state_t      i_state,
   input  logic                i_valid,
   input  logic [DATA_W_G-1:0] i_data,
   output tmr_seq_state_t      o_state
);

   localparam int LAST_POS_C = SEQ_LEN_G - 1;

   logic                w_hdrHit;
   logic [SID_W_C-1:0]  w_hdrId;
   logic [DATA_W_G-1:0] w_expWord;

   // Descending scan so the lowest matching header index is the one kept.
   always_comb begin
      w_hdrHit = 1'b0;
      w_hdrId  = '0;
      for (int k = NUM_SEQ_G - 1; k >= 0; k--) begin
         if (i_data == SEQ_G[k*SEQ_LEN_G*DATA_W_G +: DATA_W_G]) begin
            w_hdrHit = 1'b1;
            w_hdrId  = SID_W_C'(k);
         end
      end
   end

   always_comb begin
      w_expWord = '0;
      for (int k = 0; k < NUM_SEQ_G; k++) begin
         for (int j = 0; j < SEQ_LEN_G; j++) begin
            if (i_state.seq_id == SID_W_C'(k) && i_state.pos == POS_W_C'(j)) begin
               w_expWord = SEQ_G[(k*SEQ_LEN_G + j)*DATA_W_G +: DATA_W_G];
            end
         end
      end
   end

   always_comb begin
      o_state = i_state;
      case (i_state.mode)
         IDLE: begin
            o_state.pos   = '0;
            o_state.timer = '0;
            if (i_valid && w_hdrHit) begin
               o_state.mode   = MATCH;
               o_state.seq_id = w_hdrId;
               o_state.pos    = POS_W_C'(1);
            end
         end
         MATCH: begin
            if (i_valid) begin
               o_state.timer = '0;
               if (i_data == w_expWord) begin
                  if (i_state.pos == POS_W_C'(LAST_POS_C)) begin
                     o_state.mode = DONE;
                     o_state.pos  = '0;
                  end else begin
                     o_state.pos = i_state.pos + POS_W_C'(1);
                  end
               end else begin
                  o_state.mode = ERROR;
                  o_state.pos  = '0;
               end
            end else if (i_state.timer == TMR_W_C'(TIMEOUT_G - 1)) begin
               o_state.mode  = ERROR;
               o_state.pos   = '0;
               o_state.timer = '0;
            end else begin
               o_state.timer = i_state.timer + TMR_W_C'(1);
            end
         end
         DONE, ERROR: begin
            o_state.mode  = IDLE;
            o_state.pos   = '0;
            o_state.timer = '0;
         end
         default: o_state = tmr_seq_reset_state();
      endcase
   end

endmodule

// File: rtl/tmr_seq_fsm.sv
// Triple-modular-redundant sequence recogniser with one voter per replica.
// Optional replica disagreement monitor: define TMR_SEQ_FSM_MISMATCH_EN.
module tmr_seq_fsm
   import tmr_seq_pkg::*;
#(
   parameter int DATA_W_G  = DATA_W_C,
   parameter int NUM_SEQ_G = NUM_SEQ_C,
   parameter int SEQ_LEN_G = SEQ_LEN_C,
   parameter int TIMEOUT_G = TIMEOUT_C,
   parameter logic [NUM_SEQ_G*SEQ_LEN_G*DATA_W_G-1:0] SEQ_G = SEQ_C
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_a_i,
   input  logic                valid_b_i,
   input  logic                valid_c_i,
   input  logic [DATA_W_G-1:0] data_a_i,
   input  logic [DATA_W_G-1:0] data_b_i,
   input  logic [DATA_W_G-1:0] data_c_i,
   output tmr_seq_state_t      state_a_o,
   output tmr_seq_state_t      state_b_o,
   output tmr_seq_state_t      state_c_o,
   output logic                done_a_o,
   output logic                done_b_o,
   output logic                done_c_o,
   output logic                err_a_o,
   output logic                err_b_o,
   output logic                err_c_o,
   output logic [SID_W_C-1:0]  seq_id_a_o,
   output logic [SID_W_C-1:0]  seq_id_b_o,
   output logic [SID_W_C-1:0]  seq_id_c_o,
   output logic                mismatch_o,
   output logic [7:0]          mismatch_cnt_o
);

   (* dont_touch = "true" *) tmr_seq_state_t r_state_a;
   (* dont_touch = "true" *) tmr_seq_state_t r_state_b;
   (* dont_touch = "true" *) tmr_seq_state_t r_state_c;

   logic [TMR_MULTIPLICITY_C*STATE_W_C-1:0] w_allRegs;
   tmr_seq_state_t w_votedA, w_votedB, w_votedC;
   tmr_seq_state_t w_nextA, w_nextB, w_nextC;

   assign w_allRegs = {r_state_c, r_state_b, r_state_a};

   // Each replica owns its voter so a voter fault stays confined to one replica.
   majority_voter_array #(.K_MMR(TMR_MULTIPLICITY_C), .N(STATE_W_C)) u_voter_a (
      .i_data (w_allRegs),
      .o_voted(w_votedA)
   );
   majority_voter_array #(.K_MMR(TMR_MULTIPLICITY_C), .N(STATE_W_C)) u_voter_b (
      .i_data (w_allRegs),
      .o_voted(w_votedB)
   );
   majority_voter_array #(.K_MMR(TMR_MULTIPLICITY_C), .N(STATE_W_C)) u_voter_c (
      .i_data (w_allRegs),
      .o_voted(w_votedC)
   );

   tmr_seq_next_state #(
      .DATA_W_G(DATA_W_G), .NUM_SEQ_G(NUM_SEQ_G), .SEQ_LEN_G(SEQ_LEN_G),
      .TIMEOUT_G(TIMEOUT_G), .SEQ_G(SEQ_G)
   ) u_next_a (
      .i_state(w_votedA), .i_valid(valid_a_i), .i_data(data_a_i), .o_state(w_nextA)
   );
   tmr_seq_next_state #(
      .DATA_W_G(DATA_W_G), .NUM_SEQ_G(NUM_SEQ_G), .SEQ_LEN_G(SEQ_LEN_G),
      .TIMEOUT_G(TIMEOUT_G), .SEQ_G(SEQ_G)
   ) u_next_b (
      .i_state(w_votedB), .i_valid(valid_b_i), .i_data(data_b_i), .o_state(w_nextB)
   );
   tmr_seq_next_state #(
      .DATA_W_G(DATA_W_G), .NUM_SEQ_G(NUM_SEQ_G), .SEQ_LEN_G(SEQ_LEN_G),
      .TIMEOUT_G(TIMEOUT_G), .SEQ_G(SEQ_G)
   ) u_next_c (
      .i_state(w_votedC), .i_valid(valid_c_i), .i_data(data_c_i), .o_state(w_nextC)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state_a <= tmr_seq_reset_state();
         r_state_b <= tmr_seq_reset_state();
         r_state_c <= tmr_seq_reset_state();
      end else begin
         r_state_a <= w_nextA;
         r_state_b <= w_nextB;
         r_state_c <= w_nextC;
      end
   end

   assign state_a_o  = w_votedA;
   assign state_b_o  = w_votedB;
   assign state_c_o  = w_votedC;
   assign done_a_o   = (w_votedA.mode == DONE);
   assign done_b_o   = (w_votedB.mode == DONE);
   assign done_c_o   = (w_votedC.mode == DONE);
   assign err_a_o    = (w_votedA.mode == ERROR);
   assign err_b_o    = (w_votedB.mode == ERROR);
   assign err_c_o    = (w_votedC.mode == ERROR);
   assign seq_id_a_o = w_votedA.seq_id;
   assign seq_id_b_o = w_votedB.seq_id;
   assign seq_id_c_o = w_votedC.seq_id;

`ifdef TMR_SEQ_FSM_MISMATCH_EN
   logic       r_mismatch;
   logic [7:0] r_mismatchCnt;
   logic       w_differ;

   assign w_differ = (r_state_a != r_state_b) || (r_state_b != r_state_c);

   // Raw replica registers are compared, so masked upsets are still counted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_mismatch    <= 1'b0;
         r_mismatchCnt <= 8'd0;
      end else begin
         r_mismatch <= w_differ;
         if (w_differ && (r_mismatchCnt != 8'hFF)) begin
            r_mismatchCnt <= r_mismatchCnt + 8'd1;
         end
      end
   end

   assign mismatch_o     = r_mismatch;
   assign mismatch_cnt_o = r_mismatchCnt;
`else
   assign mismatch_o     = 1'b0;
   assign mismatch_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_tmr_seq_fsm.sv
// Directed self-checking bench for tmr_seq_fsm: sequences, abort, timeout,
// single-replica upset, single-replica data corruption and async reset.
module tb_tmr_seq_fsm;
   import tmr_seq_pkg::*;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic valid_a_i = 1'b0, valid_b_i = 1'b0, valid_c_i = 1'b0;
   logic [7:0] data_a_i = '0, data_b_i = '0, data_c_i = '0;
   tmr_seq_state_t state_a_o, state_b_o, state_c_o;
   logic done_a_o, done_b_o, done_c_o;
   logic err_a_o, err_b_o, err_c_o;
   logic [SID_W_C-1:0] seq_id_a_o, seq_id_b_o, seq_id_c_o;
   logic mismatch_o;
   logic [7:0] mismatch_cnt_o;

   int checkCount = 0;
   int errorCount = 0;
   tmr_seq_state_t upset;

   localparam logic [7:0] A1 = 8'hA1, A2 = 8'hA2, A3 = 8'hA3, B1 = 8'hB1;

   tmr_seq_fsm dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .valid_a_i(valid_a_i), .valid_b_i(valid_b_i), .valid_c_i(valid_c_i),
      .data_a_i(data_a_i), .data_b_i(data_b_i), .data_c_i(data_c_i),
      .state_a_o(state_a_o), .state_b_o(state_b_o), .state_c_o(state_c_o),
      .done_a_o(done_a_o), .done_b_o(done_b_o), .done_c_o(done_c_o),
      .err_a_o(err_a_o), .err_b_o(err_b_o), .err_c_o(err_c_o),
      .seq_id_a_o(seq_id_a_o), .seq_id_b_o(seq_id_b_o), .seq_id_c_o(seq_id_c_o),
      .mismatch_o(mismatch_o), .mismatch_cnt_o(mismatch_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Drive one cycle of inputs from a negedge and return at the next negedge.
   task automatic applyStimulus(input logic v, input logic [7:0] dA, input logic [7:0] dB,
                                input logic [7:0] dC);
      valid_a_i = v; valid_b_i = v; valid_c_i = v;
      data_a_i = dA; data_b_i = dB; data_c_i = dC;
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic applyWord(input logic v, input logic [7:0] d);
      applyStimulus(v, d, d, d);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      checkCount++;
      if ({state_a_o.mode, state_b_o.mode, state_c_o.mode} !== {IDLE, IDLE, IDLE}) begin
         errorCount++;
         $display("[TB] FAIL reset_mode: got %b expected %b",
                  {state_a_o.mode, state_b_o.mode, state_c_o.mode}, 6'b0);
      end
      checkCount++;
      if ({done_a_o, done_b_o, done_c_o, err_a_o, err_b_o, err_c_o,
           seq_id_a_o, seq_id_b_o, seq_id_c_o} !== 9'b0) begin
         errorCount++;
         $display("[TB] FAIL reset_flags: got %b expected %b",
                  {done_a_o, done_b_o, done_c_o, err_a_o, err_b_o, err_c_o,
                   seq_id_a_o, seq_id_b_o, seq_id_c_o}, 9'b0);
      end
      checkCount++;
      if ({mismatch_o, mismatch_cnt_o} !== 9'b0) begin
         errorCount++;
         $display("[TB] FAIL reset_mismatch: got %b/%0d expected 0/0", mismatch_o, mismatch_cnt_o);
      end
      rst_i = 1'b0;
      applyWord(1'b0, 8'h00);
   endtask

   task automatic test_sequence_a();
      applyWord(1'b1, A1);
      checkCount++;
      if (state_a_o.mode !== MATCH || state_a_o.pos !== POS_W_C'(1) || seq_id_a_o !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL seqA_after_A1: got mode %0d pos %0d id %0d expected 1 1 0",
                  state_a_o.mode, state_a_o.pos, seq_id_a_o);
      end
      applyWord(1'b1, A2);
      checkCount++;
      if (state_b_o.pos !== POS_W_C'(2)) begin
         errorCount++;
         $display("[TB] FAIL seqA_after_A2_pos: got %0d expected 2", state_b_o.pos);
      end
      applyWord(1'b1, A3);
      checkCount++;
      if ({done_a_o, done_b_o, done_c_o, err_a_o, err_b_o, err_c_o} !== 6'b111000) begin
         errorCount++;
         $display("[TB] FAIL seqA_done: got %b expected %b",
                  {done_a_o, done_b_o, done_c_o, err_a_o, err_b_o, err_c_o}, 6'b111000);
      end
      checkCount++;
      if ({seq_id_a_o, seq_id_b_o, seq_id_c_o} !== 3'b000) begin
         errorCount++;
         $display("[TB] FAIL seqA_id: got %b expected 000", {seq_id_a_o, seq_id_b_o, seq_id_c_o});
      end
      applyWord(1'b0, 8'h00);
      checkCount++;
      if (done_a_o !== 1'b0 || state_c_o.mode !== IDLE) begin
         errorCount++;
         $display("[TB] FAIL seqA_pulse_end: got done %b mode %0d expected 0 0", done_a_o, state_c_o.mode);
      end
   endtask

   task automatic test_abort();
      applyWord(1'b1, B1);
      checkCount++;
      if (state_a_o.mode !== MATCH || seq_id_a_o !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL abort_B1: got mode %0d id %0d expected 1 1", state_a_o.mode, seq_id_a_o);
      end
      applyWord(1'b1, A2);
      checkCount++;
      if ({err_a_o, err_b_o, err_c_o, done_a_o, done_b_o, done_c_o} !== 6'b111000) begin
         errorCount++;
         $display("[TB] FAIL abort_err: got %b expected %b",
                  {err_a_o, err_b_o, err_c_o, done_a_o, done_b_o, done_c_o}, 6'b111000);
      end
      applyWord(1'b0, 8'h00);
      checkCount++;
      if (state_a_o.mode !== IDLE || err_a_o !== 1'b0 ||
          {seq_id_a_o, seq_id_b_o, seq_id_c_o} !== 3'b111) begin
         errorCount++;
         $display("[TB] FAIL abort_idle: got mode %0d err %b ids %b expected 0 0 111",
                  state_a_o.mode, err_a_o, {seq_id_a_o, seq_id_b_o, seq_id_c_o});
      end
   endtask

   task automatic test_timeout();
      applyWord(1'b1, A1);
      repeat (15) applyWord(1'b0, 8'h00);
      checkCount++;
      if (state_a_o.mode !== MATCH || state_a_o.timer !== TMR_W_C'(15)) begin
         errorCount++;
         $display("[TB] FAIL timeout_15idle: got mode %0d timer %0d expected 1 15",
                  state_a_o.mode, state_a_o.timer);
      end
      applyWord(1'b1, A2);
      checkCount++;
      if (state_b_o.mode !== MATCH || state_b_o.pos !== POS_W_C'(2) || state_b_o.timer !== '0) begin
         errorCount++;
         $display("[TB] FAIL timeout_valid_wins: got mode %0d pos %0d timer %0d expected 1 2 0",
                  state_b_o.mode, state_b_o.pos, state_b_o.timer);
      end
      applyWord(1'b1, A3);
      checkCount++;
      if ({done_a_o, done_b_o, done_c_o} !== 3'b111) begin
         errorCount++;
         $display("[TB] FAIL timeout_late_done: got %b expected 111", {done_a_o, done_b_o, done_c_o});
      end
      applyWord(1'b0, 8'h00);
      applyWord(1'b1, A1);
      repeat (15) applyWord(1'b0, 8'h00);
      checkCount++;
      if ({err_a_o, err_b_o, err_c_o} !== 3'b000) begin
         errorCount++;
         $display("[TB] FAIL timeout_early: got %b expected 000", {err_a_o, err_b_o, err_c_o});
      end
      applyWord(1'b0, 8'h00);
      checkCount++;
      if ({err_a_o, err_b_o, err_c_o} !== 3'b111) begin
         errorCount++;
         $display("[TB] FAIL timeout_fire: got %b expected 111", {err_a_o, err_b_o, err_c_o});
      end
      applyWord(1'b0, 8'h00);
      checkCount++;
      if (state_c_o.mode !== IDLE) begin
         errorCount++;
         $display("[TB] FAIL timeout_idle: got %0d expected 0", state_c_o.mode);
      end
   endtask

   task automatic test_upset();
      applyWord(1'b1, A1);
      applyWord(1'b1, A2);
      upset = dut.r_state_b;
      upset.mode = ERROR;
      force dut.r_state_b = upset;
      #1;
      release dut.r_state_b;
      checkCount++;
      if (dut.r_state_b.mode !== ERROR || state_b_o.mode !== MATCH || err_b_o !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL upset_masked: got raw %0d voted %0d err %b expected 3 1 0",
                  dut.r_state_b.mode, state_b_o.mode, err_b_o);
      end
      applyWord(1'b1, A3);
      checkCount++;
      if ({done_a_o, done_b_o, done_c_o} !== 3'b111 || dut.r_state_b.mode !== DONE) begin
         errorCount++;
         $display("[TB] FAIL upset_done: got %b raw %0d expected 111 2",
                  {done_a_o, done_b_o, done_c_o}, dut.r_state_b.mode);
      end
`ifdef TMR_SEQ_FSM_MISMATCH_EN
      checkCount++;
      if (mismatch_o !== 1'b1 || mismatch_cnt_o !== 8'd1) begin
         errorCount++;
         $display("[TB] FAIL upset_mismatch: got %b/%0d expected 1/1", mismatch_o, mismatch_cnt_o);
      end
`else
      checkCount++;
      if (mismatch_o !== 1'b0 || mismatch_cnt_o !== 8'd0) begin
         errorCount++;
         $display("[TB] FAIL upset_mismatch_off: got %b/%0d expected 0/0", mismatch_o, mismatch_cnt_o);
      end
`endif
      applyWord(1'b0, 8'h00);
`ifdef TMR_SEQ_FSM_MISMATCH_EN
      checkCount++;
      if (mismatch_o !== 1'b0 || mismatch_cnt_o !== 8'd1) begin
         errorCount++;
         $display("[TB] FAIL upset_mismatch_clear: got %b/%0d expected 0/1", mismatch_o, mismatch_cnt_o);
      end
`endif
   endtask

   task automatic test_corrupt_c();
      applyWord(1'b1, A1);
      applyStimulus(1'b1, A2, A2, 8'h55);
      checkCount++;
      if (dut.r_state_c.mode !== ERROR || state_c_o.mode !== MATCH || err_c_o !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL corrupt_c_vote: got raw %0d voted %0d err %b expected 3 1 0",
                  dut.r_state_c.mode, state_c_o.mode, err_c_o);
      end
      applyWord(1'b1, A3);
      checkCount++;
      if ({done_a_o, done_b_o, done_c_o} !== 3'b111 || dut.r_state_c.mode !== DONE) begin
         errorCount++;
         $display("[TB] FAIL corrupt_c_done: got %b raw %0d expected 111 2",
                  {done_a_o, done_b_o, done_c_o}, dut.r_state_c.mode);
      end
`ifdef TMR_SEQ_FSM_MISMATCH_EN
      checkCount++;
      if (mismatch_o !== 1'b1 || mismatch_cnt_o !== 8'd2) begin
         errorCount++;
         $display("[TB] FAIL corrupt_c_mismatch: got %b/%0d expected 1/2", mismatch_o, mismatch_cnt_o);
      end
`endif
      applyWord(1'b0, 8'h00);
      checkCount++;
      if (dut.r_state_c.mode !== IDLE) begin
         errorCount++;
         $display("[TB] FAIL corrupt_c_realign: got %0d expected 0", dut.r_state_c.mode);
      end
   endtask

   task automatic test_async_reset();
      applyWord(1'b1, A1);
      applyWord(1'b1, A2);
      valid_a_i = 1'b0; valid_b_i = 1'b0; valid_c_i = 1'b0;
      #2 rst_i = 1'b1;
      #1;
      checkCount++;
      if ({state_a_o.mode, state_b_o.mode, state_c_o.mode} !== {IDLE, IDLE, IDLE} ||
          state_a_o.pos !== '0 ||
          {done_a_o, done_b_o, done_c_o, err_a_o, err_b_o, err_c_o} !== 6'b0 ||
          mismatch_cnt_o !== 8'd0) begin
         errorCount++;
         $display("[TB] FAIL async_reset: got modes %b pos %0d flags %b cnt %0d expected 0 0 0 0",
                  {state_a_o.mode, state_b_o.mode, state_c_o.mode}, state_a_o.pos,
                  {done_a_o, done_b_o, done_c_o, err_a_o, err_b_o, err_c_o}, mismatch_cnt_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      applyWord(1'b0, 8'h00);
      checkCount++;
      if ({done_a_o, done_b_o, done_c_o, err_a_o, err_b_o, err_c_o} !== 6'b0) begin
         errorCount++;
         $display("[TB] FAIL async_reset_nopulse: got %b expected 000000",
                  {done_a_o, done_b_o, done_c_o, err_a_o, err_b_o, err_c_o});
      end
      applyWord(1'b1, A1);
      applyWord(1'b1, A2);
      applyWord(1'b1, A3);
      checkCount++;
      if ({done_a_o, done_b_o, done_c_o} !== 3'b111 || seq_id_a_o !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL async_reset_resume: got %b id %0d expected 111 0",
                  {done_a_o, done_b_o, done_c_o}, seq_id_a_o);
      end
   endtask

   initial begin
      test_reset();
      test_sequence_a();
      test_abort();
      test_timeout();
      test_upset();
      test_corrupt_c();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
